usb_packet_receiver: RTL and testbench
======================================

# usb_packet_receiver

- Receive-side counterpart of the protocol-handler transmit path; sits between the bus pins (DP/DM) and the protocol-handler FSM.
- Converts the serial line back into packets: DP/DM decode, NRZI decode, bit unstuffing, PID check and CRC16 check.
- Accepts ACK, NAK and DATA0 (64-bit payload) packets.
- Reports either a one-cycle "packet received" strobe, a one-cycle error strobe with a code, or a timeout.

## Interface
Parameters:
- TIMEOUT, 255, number of cycles in WAIT_SYNC without a K before rx_timeout fires.

Ports:
- clock  in  1  system clock; one line bit per cycle.
- reset_n  in  1  asynchronous, active-low reset.
- rx_start  in  1  one-cycle pulse to begin listening for a response; ignored unless in IDLE.
- DP_in  in  1  bus D+, already synchronous to clock.
- DM_in  in  1  bus D-, already synchronous to clock.
- rcv_ACK  out  1  one-cycle pulse: valid ACK received.
- rcv_NAK  out  1  one-cycle pulse: valid NAK received.
- rcv_DATA0  out  1  one-cycle pulse: valid DATA0 received; data_out is valid.
- data_out  out  64  DATA0 payload, first-received bit at bit 0; held until the next valid DATA0.
- rcv_error  out  1  one-cycle pulse: packet rejected.
- err_code  out  3  reason code; valid with rcv_error, held afterwards.
- rx_timeout  out  1  one-cycle pulse: no SYNC within TIMEOUT cycles.
- rx_busy  out  1  high in every state except IDLE.

## Operation
Line states:
- J = (DP,DM) = 10; K = 01; SE0 = 00; 11 is illegal and treated as a framing error.
- NRZI decode: no change from the previous J/K state gives 1; a change gives 0. The previous-state register is set to J on entry to WAIT_SYNC.

States:
- IDLE: rx_start → WAIT_SYNC; the timeout counter is cleared.
- WAIT_SYNC: line is J (idle). The first K sampled → SYNC; that K counts as sync bit 0. If the counter reaches TIMEOUT first, pulse rx_timeout → IDLE.
- SYNC: decoded bits must equal 0,0,0,0,0,0,0,1 (8 bits including the first K). On mismatch, err_code 1 (sync).
- PID: 8 bits, LSB first. The ones-run counter is cleared on entry to PID.
  - The upper nibble must equal the bitwise inverse of the lower nibble.
  - Accepted PIDs are 8'hD2 (ACK), 8'h5A (NAK) and 8'hC3 (DATA0).
  - Any other PID gives err_code 2 (pid).
  - ACK/NAK → EOP1; DATA0 → DATA.
- DATA: 80 unstuffed bits: 64 payload bits, then 16 CRC bits.
  - Payload shifts into a 64-bit register.
  - All 80 bits feed a serial CRC16 checker: init 16'hFFFF, fb = bit ^ crc[15], crc = {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
  - After bit 80: if crc != 16'h800D, err_code 4 (crc), otherwise → EOP1.
- EOP1, EOP2: the line must be SE0 in both.
- EOP_J: the line must be J.
  - On J, pulse the matching rcv_* strobe; for DATA0, copy the payload into data_out in the same edge.
  - Then → IDLE.

Bit unstuffing (PID and DATA states):
- A counter tracks consecutive decoded 1s.
- After six 1s, the next bit must be 0. That bit is discarded: it does not advance the field counter, the shift register or the CRC. The ones counter then clears.
- If that bit is 1 instead, err_code 3 (stuff).
- A stuff bit due after the final CRC bit is consumed in DATA before moving to EOP1.

Framing errors (err_code 5):
- SE0 or 11 seen in SYNC, PID or DATA.
- Anything other than SE0 in EOP1 or EOP2.
- Anything other than J in EOP_J.

Error handling:
- Any error pulses rcv_error, latches err_code, and goes → IDLE. The rest of the packet is ignored; there is no resync.
- err_code values: 0 none, 1 sync, 2 pid, 3 stuff, 4 crc, 5 framing.

## Timing
- Reset values: all pulses 0, data_out 0, err_code 0, rx_busy 0, state IDLE.
- Reset asserted mid-packet aborts immediately. No strobe or error is issued for the aborted packet.
- rx_start sampled at edge N: rx_busy is high from after edge N. The first sample considered for SYNC is at edge N+1.
- All result strobes are registered. Each is high for the single cycle following the edge that sampled the deciding bit (the EOP J, the bad bit, or the TIMEOUT-th idle cycle).
- Exactly one of rcv_ACK, rcv_NAK, rcv_DATA0, rcv_error, rx_timeout pulses per rx_start.
- rx_busy falls in the same cycle the strobe is high.
- Packet-length latency:
  - ACK/NAK: 8 SYNC + 8 PID (+ stuffed bits) + 3 EOP samples.
  - DATA0: adds 80 data bits plus stuffed bits.
- rx_start while rx_busy is ignored.

## Test plan
- ACK from the team's transmit path (SYNC, 8'hD2, SE0 SE0 J) after rx_start → rcv_ACK single pulse on the edge after the J sample; err_code stays 0.
- DATA0 with data 64'h0123_4567_89AB_CDEF and the correct CRC16 → rcv_DATA0 pulse; data_out = 64'h0123_4567_89AB_CDEF.
- DATA0 with data 64'hFFFF_FFFF_FFFF_FFFF (stuff bits inserted) → rcv_DATA0; data_out all ones.
- Same packet with the stuff 0 replaced by 1 → rcv_error with err_code 3.
- DATA0 with one payload bit flipped after CRC generation → rcv_error, err_code 4, data_out unchanged.
- PID 8'hD3 → rcv_error, err_code 2.
- rx_start then line held at J for 255 cycles → rx_timeout pulse; rx_busy falls.
- reset_n low mid-DATA → all outputs 0 and no strobe; the next rx_start plus an ACK → rcv_ACK.

Source files
------------

// File: rtl/usb_packet_receiver.sv
// Receive path between the USB line (DP/DM) and the protocol FSM: line decode, NRZI,
// bit unstuffing, PID and CRC16 checks; reports ACK/NAK/DATA0, an error code or a timeout.
module usb_packet_receiver #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_start,
  input  logic        DP_in,
  input  logic        DM_in,
  output logic        rcv_ACK,
  output logic        rcv_NAK,
  output logic        rcv_DATA0,
  output logic [63:0] data_out,
  output logic        rcv_error,
  output logic [2:0]  err_code,
  output logic        rx_timeout,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_SYNC, S_PID, S_DATA, S_EOP1, S_EOP2, S_EOP_J
  } state_t;

  localparam int             TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]     PID_ACK   = 8'hD2;
  localparam logic [7:0]     PID_NAK   = 8'h5A;
  localparam logic [7:0]     PID_DATA0 = 8'hC3;
  localparam logic [15:0]    CRC_POLY  = 16'h8005;
  localparam logic [15:0]    CRC_RESID = 16'h800D;
  localparam logic [2:0]     ERR_SYNC  = 3'd1;
  localparam logic [2:0]     ERR_PID   = 3'd2;
  localparam logic [2:0]     ERR_STUFF = 3'd3;
  localparam logic [2:0]     ERR_CRC   = 3'd4;
  localparam logic [2:0]     ERR_FRAME = 3'd5;

  state_t         state_q;
  logic [TW-1:0]  tmo_q;
  logic [6:0]     bit_cnt_q;
  logic [2:0]     ones_q;
  logic           prev_k_q;
  logic [7:0]     pid_q;
  logic [15:0]    crc_q;
  logic [63:0]    payload_q;

  logic        line_j, line_k, line_se0, line_bad;
  logic        bit_dec, crc_fb, stuff_due;
  logic [2:0]  ones_d;
  logic [7:0]  pid_d;
  logic [15:0] crc_d;

  assign line_j    = DP_in & ~DM_in;
  assign line_k    = ~DP_in & DM_in;
  assign line_se0  = ~DP_in & ~DM_in;
  assign line_bad  = ~(line_j | line_k);
  assign bit_dec   = (line_k == prev_k_q);
  assign stuff_due = (ones_q == 3'd6);
  assign ones_d    = bit_dec ? ones_q + 3'd1 : 3'd0;
  assign pid_d     = {bit_dec, pid_q[7:1]};
  assign crc_fb    = bit_dec ^ crc_q[15];
  assign crc_d     = {crc_q[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
  assign rx_busy   = (state_q != S_IDLE);

  // NOTE: all state here is updated with non-blocking assignments so every branch reads
  // the pre-edge values; blocking would let one update leak into the next decision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      bit_cnt_q  <= '0;
      ones_q     <= '0;
      prev_k_q   <= 1'b0;
      pid_q      <= '0;
      crc_q      <= 16'hFFFF;
      payload_q  <= '0;
      rcv_ACK    <= 1'b0;
      rcv_NAK    <= 1'b0;
      rcv_DATA0  <= 1'b0;
      data_out   <= '0;
      rcv_error  <= 1'b0;
      err_code   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      rcv_ACK    <= 1'b0;
      rcv_NAK    <= 1'b0;
      rcv_DATA0  <= 1'b0;
      rcv_error  <= 1'b0;
      rx_timeout <= 1'b0;
      unique case (state_q)
        S_IDLE: if (rx_start) begin
          state_q  <= S_WAIT_SYNC;
          tmo_q    <= '0;
          prev_k_q <= 1'b0;
        end
        S_WAIT_SYNC: begin
          if (line_k) begin
            state_q   <= S_SYNC;
            prev_k_q  <= 1'b1;
            bit_cnt_q <= 7'd1;
          end else if (tmo_q == TMO_LAST) begin
            rx_timeout <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_SYNC: begin
          prev_k_q <= line_k;
          if (line_bad) begin
            rcv_error <= 1'b1; err_code <= ERR_FRAME; state_q <= S_IDLE;
          end else if (bit_dec != (bit_cnt_q == 7'd7)) begin
            rcv_error <= 1'b1; err_code <= ERR_SYNC; state_q <= S_IDLE;
          end else if (bit_cnt_q == 7'd7) begin
            state_q   <= S_PID;
            bit_cnt_q <= '0;
            ones_q    <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 7'd1;
          end
        end
        S_PID: begin
          prev_k_q <= line_k;
          if (line_bad) begin
            rcv_error <= 1'b1; err_code <= ERR_FRAME; state_q <= S_IDLE;
          end else if (stuff_due) begin
            if (bit_dec) begin
              rcv_error <= 1'b1; err_code <= ERR_STUFF; state_q <= S_IDLE;
            end
            ones_q <= '0;
          end else begin
            ones_q <= ones_d;
            pid_q  <= pid_d;
            bit_cnt_q <= bit_cnt_q + 7'd1;
            // Only the three accepted PIDs pass; each already has upper nibble == ~lower.
            if (bit_cnt_q == 7'd7) begin
              bit_cnt_q <= '0;
              crc_q     <= 16'hFFFF;
              if (pid_d == PID_ACK || pid_d == PID_NAK) begin
                state_q <= S_EOP1;
              end else if (pid_d == PID_DATA0) begin
                state_q <= S_DATA;
              end else begin
                rcv_error <= 1'b1; err_code <= ERR_PID; state_q <= S_IDLE;
              end
            end
          end
        end
        S_DATA: begin
          prev_k_q <= line_k;
          if (line_bad) begin
            rcv_error <= 1'b1; err_code <= ERR_FRAME; state_q <= S_IDLE;
          end else if (stuff_due) begin
            if (bit_dec) begin
              rcv_error <= 1'b1; err_code <= ERR_STUFF; state_q <= S_IDLE;
            end else if (bit_cnt_q == 7'd80) begin
              state_q <= S_EOP1;
            end
            ones_q <= '0;
          end else begin
            ones_q    <= ones_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_q + 7'd1;
            if (bit_cnt_q < 7'd64) payload_q <= {bit_dec, payload_q[63:1]};
            // Bit 80 decides the CRC; a trailing stuff bit keeps us here for one more sample.
            if (bit_cnt_q == 7'd79) begin
              if (crc_d != CRC_RESID) begin
                rcv_error <= 1'b1; err_code <= ERR_CRC; state_q <= S_IDLE;
              end else if (ones_d != 3'd6) begin
                state_q <= S_EOP1;
              end
            end
          end
        end
        S_EOP1, S_EOP2: begin
          if (line_se0) begin
            state_q <= (state_q == S_EOP1) ? S_EOP2 : S_EOP_J;
          end else begin
            rcv_error <= 1'b1; err_code <= ERR_FRAME; state_q <= S_IDLE;
          end
        end
        S_EOP_J: begin
          state_q <= S_IDLE;
          if (line_j) begin
            rcv_ACK   <= (pid_q == PID_ACK);
            rcv_NAK   <= (pid_q == PID_NAK);
            rcv_DATA0 <= (pid_q == PID_DATA0);
            if (pid_q == PID_DATA0) data_out <= payload_q;
          end else begin
            rcv_error <= 1'b1; err_code <= ERR_FRAME;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_packet_receiver.sv
// Bench for usb_packet_receiver: a transmit model builds line symbols, expected events go to
// a scoreboard queue, and a monitor pops and compares them whenever a result strobe fires.
module tb_usb_packet_receiver;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  typedef enum int {EV_ACK, EV_NAK, EV_DATA0, EV_ERR, EV_TMO} ev_t;
  typedef struct {
    ev_t         ev;
    logic [2:0]  code;
    logic [63:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_start = 1'b0;
  logic        DP_in = 1'b1;
  logic        DM_in = 1'b0;
  logic        rcv_ACK, rcv_NAK, rcv_DATA0, rcv_error, rx_timeout, rx_busy;
  logic [63:0] data_out;
  logic [2:0]  err_code;

  exp_t        sb_q[$];
  logic [1:0]  line_q[$];
  bit          raw_q[$];
  int          tx_ones;
  bit          bad_stuff_pending;
  logic [63:0] exp_data = '0;
  int          errors = 0;
  int          checks = 0;

  usb_packet_receiver #(.TIMEOUT(255)) dut (
    .clock(clock), .reset_n(reset_n), .rx_start(rx_start),
    .DP_in(DP_in), .DM_in(DM_in),
    .rcv_ACK(rcv_ACK), .rcv_NAK(rcv_NAK), .rcv_DATA0(rcv_DATA0),
    .data_out(data_out), .rcv_error(rcv_error), .err_code(err_code),
    .rx_timeout(rx_timeout), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin : monitor
    int   n;
    ev_t  obs;
    exp_t e;
    if (reset_n) begin
      n = int'(rcv_ACK) + int'(rcv_NAK) + int'(rcv_DATA0) + int'(rcv_error) + int'(rx_timeout);
      if (n > 0) begin
        checks++;
        obs = rcv_ACK ? EV_ACK : rcv_NAK ? EV_NAK : rcv_DATA0 ? EV_DATA0 : rcv_error ? EV_ERR : EV_TMO;
        if (n > 1) begin
          errors++;
          $display("FAIL strobe_onehot: %0d strobes high at once, required 1", n);
        end else if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got ev=%0d code=%0d, required no event", obs, err_code);
        end else begin
          e = sb_q.pop_front();
          if (obs !== e.ev || (e.ev == EV_ERR && err_code !== e.code) || data_out !== e.data) begin
            errors++;
            $display("FAIL event: got ev=%0d code=%0d data=%h, required ev=%0d code=%0d data=%h",
                     obs, err_code, data_out, e.ev, e.code, e.data);
          end
        end
      end
    end
  end

  task automatic expect_ev(input ev_t ev, input logic [2:0] code);
    exp_t e;
    e.ev = ev; e.code = code; e.data = exp_data;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] crc16(input logic [63:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  task automatic push_stuffed(input bit b);
    raw_q.push_back(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (tx_ones == 6) begin
      raw_q.push_back(bad_stuff_pending);
      bad_stuff_pending = 1'b0;
      tx_ones = 0;
    end
  endtask

  // Builds: 2 idle J, SYNC, PID, optional payload + CRC16, SE0 SE0 J.
  task automatic build(input logic [7:0] pid, input bit with_data, input logic [63:0] d,
                       input bit flip, input bit bad_stuff);
    logic [15:0] c;
    logic [63:0] dd;
    logic        lvl;
    raw_q.delete();
    line_q.delete();
    bad_stuff_pending = bad_stuff;
    repeat (7) raw_q.push_back(1'b0);
    raw_q.push_back(1'b1);
    tx_ones = 0;
    for (int i = 0; i < 8; i++) push_stuffed(pid[i]);
    if (with_data) begin
      c  = crc16(d);
      dd = flip ? (d ^ 64'h1) : d;
      for (int i = 0; i < 64; i++) push_stuffed(dd[i]);
      for (int i = 0; i < 16; i++) push_stuffed(~c[15-i]);
    end
    line_q.push_back(SYM_J);
    line_q.push_back(SYM_J);
    lvl = 1'b1;
    foreach (raw_q[i]) begin
      if (!raw_q[i]) lvl = ~lvl;
      line_q.push_back(lvl ? SYM_J : SYM_K);
    end
    line_q.push_back(SYM_SE0);
    line_q.push_back(SYM_SE0);
    line_q.push_back(SYM_J);
  endtask

  task automatic start_rx();
    rx_start = 1'b1;
    @(posedge clock); #1;
    rx_start = 1'b0;
  endtask

  // Drives up to n symbols, one per cycle; rx_start is pulsed during symbol pulse_at.
  task automatic play(input int n, input int pulse_at);
    for (int i = 0; i < line_q.size() && i < n; i++) begin
      {DP_in, DM_in} = line_q[i];
      rx_start = (i == pulse_at);
      @(posedge clock); #1;
    end
    rx_start = 1'b0;
    {DP_in, DM_in} = SYM_J;
    line_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({rcv_ACK, rcv_NAK, rcv_DATA0, rcv_error, rx_timeout, rx_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000",
               {rcv_ACK, rcv_NAK, rcv_DATA0, rcv_error, rx_timeout, rx_busy});
    end
    checks++;
    if (data_out !== 64'h0 || err_code !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: got data=%h code=%0d, required 0/0", data_out, err_code);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_ack();
    build(8'hD2, 1'b0, '0, 1'b0, 1'b0);
    expect_ev(EV_ACK, 3'd0);
    start_rx();
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", rx_busy);
    end
    play(1000, -1);
    checks++;
    if (rcv_ACK !== 1'b1 || rx_busy !== 1'b0 || err_code !== 3'd0) begin
      errors++;
      $display("FAIL ack_timing: got ack=%b busy=%b code=%0d, required 1/0/0", rcv_ACK, rx_busy, err_code);
    end
    @(posedge clock); #1;
    checks++;
    if (rcv_ACK !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_pulse: got %b, required 0", rcv_ACK);
    end
  endtask

  task automatic test_nak();
    build(8'h5A, 1'b0, '0, 1'b0, 1'b0);
    expect_ev(EV_NAK, 3'd0);
    start_rx();
    play(1000, -1);
    checks++;
    if (rcv_NAK !== 1'b1 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL nak_timing: got nak=%b busy=%b, required 1/0", rcv_NAK, rx_busy);
    end
  endtask

  task automatic test_data0(input logic [63:0] d);
    build(8'hC3, 1'b1, d, 1'b0, 1'b0);
    exp_data = d;
    expect_ev(EV_DATA0, 3'd0);
    start_rx();
    play(1000, -1);
    checks++;
    if (rcv_DATA0 !== 1'b1 || data_out !== d) begin
      errors++;
      $display("FAIL data0_timing: got strobe=%b data=%h, required 1/%h", rcv_DATA0, data_out, d);
    end
  endtask

  task automatic test_error(input logic [7:0] pid, input bit with_data, input logic [63:0] d,
                            input bit flip, input bit bad_stuff, input logic [2:0] code);
    build(pid, with_data, d, flip, bad_stuff);
    expect_ev(EV_ERR, code);
    start_rx();
    play(1000, -1);
  endtask

  task automatic test_sync_err();
    build(8'hD2, 1'b0, '0, 1'b0, 1'b0);
    line_q[5] = (line_q[5] == SYM_J) ? SYM_K : SYM_J;
    expect_ev(EV_ERR, 3'd1);
    start_rx();
    play(1000, -1);
  endtask

  task automatic test_frame_err();
    build(8'hD2, 1'b0, '0, 1'b0, 1'b0);
    line_q[line_q.size() - 3] = SYM_J;
    expect_ev(EV_ERR, 3'd5);
    start_rx();
    play(1000, -1);
  endtask

  task automatic test_timeout();
    expect_ev(EV_TMO, 3'd0);
    start_rx();
    repeat (254) begin
      @(posedge clock); #1;
    end
    checks++;
    if (rx_timeout !== 1'b0 || rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got tmo=%b busy=%b, required 0/1", rx_timeout, rx_busy);
    end
    @(posedge clock); #1;
    checks++;
    if (rx_timeout !== 1'b1 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: got tmo=%b busy=%b, required 1/0", rx_timeout, rx_busy);
    end
  endtask

  task automatic test_reset_mid_data();
    build(8'hC3, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
    start_rx();
    play(40, -1);
    reset_n = 1'b0;
    #1;
    exp_data = '0;
    checks++;
    if ({rcv_ACK, rcv_NAK, rcv_DATA0, rcv_error, rx_timeout, rx_busy} !== 6'b0 ||
        data_out !== 64'h0 || err_code !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b data=%h code=%0d, required all 0",
               {rcv_ACK, rcv_NAK, rcv_DATA0, rcv_error, rx_timeout, rx_busy}, data_out, err_code);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_ack();
  endtask

  task automatic test_ignore_start();
    build(8'h5A, 1'b0, '0, 1'b0, 1'b0);
    expect_ev(EV_NAK, 3'd0);
    start_rx();
    play(1000, 12);
  endtask

  task automatic test_back_to_back();
    build(8'hD2, 1'b0, '0, 1'b0, 1'b0);
    expect_ev(EV_ACK, 3'd0);
    start_rx();
    play(1000, -1);
    build(8'h5A, 1'b0, '0, 1'b0, 1'b0);
    expect_ev(EV_NAK, 3'd0);
    start_rx();
    play(1000, -1);
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nak();
    test_data0(64'h0123_4567_89AB_CDEF);
    test_data0(64'hFFFF_FFFF_FFFF_FFFF);
    test_error(8'hC3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 3'd3);
    test_error(8'hC3, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 3'd4);
    test_error(8'hD3, 1'b0, '0, 1'b0, 1'b0, 3'd2);
    test_sync_err();
    test_frame_err();
    test_timeout();
    test_ignore_start();
    test_reset_mid_data();
    test_back_to_back();
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d unmatched, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
